sequence_gen: RTL and testbench

//   Serial pattern transmitter: emits a WIDTH-bit word one bit per CLK on SER_OUT,

---
 rtl/sequence_gen.sv | 120 ++++++++++++
 tb/tb_sequence_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sequence_gen.sv
// Serial pattern transmitter: sends a WIDTH-bit word (D_IN or PATTERN) one bit per clock, repeated REPEAT+1 times.
// Optional macro SEQ_GEN_PARITY_EN appends an even-parity bit after every word.
module sequence_gen #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] PATTERN   = WIDTH'(8'hD5),
  parameter bit               MSB_FIRST = 1'b0,
  parameter int unsigned      RPT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             use_din,
  input  logic [WIDTH-1:0] d_in,
  input  logic [RPT_W-1:0] repeats,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SEQ_GEN_PARITY_EN
    , PAR = 2'd2
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [RPT_W-1:0] word_cnt;

  logic [WIDTH-1:0] start_word_c;
  logic             last_data_c;
  logic             word_end_c;

  // Bit that leaves first from a word, and the word with that bit consumed.
  function automatic logic lead(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign start_word_c = use_din ? d_in : PATTERN;
  assign last_data_c  = (state == SHIFT) && (bit_cnt == LAST_BIT);
`ifdef SEQ_GEN_PARITY_EN
  assign word_end_c   = (state == PAR);
`else
  assign word_end_c   = last_data_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word      <= '0;
      sreg      <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        // Abort beats start when both arrive in IDLE.
        if (start && !abort) begin
          word      <= start_word_c;
          word_cnt  <= repeats;
          sreg      <= advance(start_word_c);
          ser_out   <= lead(start_word_c);
          bit_cnt   <= '0;
          ser_valid <= 1'b1;
          busy      <= 1'b1;
          state     <= SHIFT;
        end
      end else if (abort) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        ser_out   <= 1'b0;
        ser_valid <= 1'b0;
        busy      <= 1'b0;
      end else if (word_end_c) begin
        if (word_cnt != '0) begin
          // Reload without a gap cycle; valid stays high.
          word_cnt <= word_cnt - RPT_W'(1);
          sreg     <= advance(word);
          ser_out  <= lead(word);
          bit_cnt  <= '0;
          state    <= SHIFT;
        end else begin
          state     <= IDLE;
          bit_cnt   <= '0;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
`ifdef SEQ_GEN_PARITY_EN
      end else if (last_data_c) begin
        ser_out <= ^word;
        state   <= PAR;
`endif
      end else begin
        ser_out <= lead(sreg);
        sreg    <= advance(sreg);
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sequence_gen.sv
// Self-checking bench for sequence_gen: LSB-first and MSB-first instances checked every cycle
// against a bit-queue reference model. Honours SEQ_GEN_PARITY_EN when defined.
module tb_sequence_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, use_din;
  logic [7:0] d_in;
  logic [3:0] rpt;
  logic       so_l, sv_l, bz_l, dn_l;
  logic       so_m, sv_m, bz_m, dn_m;

  int total  = 0;
  int passed = 0;

  // Model: each queue entry holds {msb_first_bit, lsb_first_bit} for one future valid cycle.
  bit [1:0] q[$];
  bit       exp_valid = 1'b0;
  bit       exp_done  = 1'b0;
  bit [1:0] exp_out   = 2'b00;

  sequence_gen #(.WIDTH(8), .PATTERN(8'hD5), .MSB_FIRST(1'b0), .RPT_W(4)) u_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .use_din(use_din),
    .d_in(d_in), .repeats(rpt), .ser_out(so_l), .ser_valid(sv_l), .busy(bz_l), .done(dn_l)
  );

  sequence_gen #(.WIDTH(8), .PATTERN(8'hD5), .MSB_FIRST(1'b1), .RPT_W(4)) u_msb (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .use_din(use_din),
    .d_in(d_in), .repeats(rpt), .ser_out(so_m), .ser_valid(sv_m), .busy(bz_m), .done(dn_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, expv);
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit [7:0] w;
    exp_done = 1'b0;
    if (exp_valid) begin
      if (abort) begin
        q.delete();
        exp_valid = 1'b0;
        exp_out   = 2'b00;
      end else if (q.size() > 0) begin
        exp_out = q.pop_front();
      end else begin
        exp_valid = 1'b0;
        exp_out   = 2'b00;
        exp_done  = 1'b1;
      end
    end else if (start && !abort) begin
      w = use_din ? d_in : 8'hD5;
      for (int n = 0; n <= int'(rpt); n++) begin
        for (int i = 0; i < 8; i++) q.push_back({w[7 - i], w[i]});
`ifdef SEQ_GEN_PARITY_EN
        q.push_back({^w, ^w});
`endif
      end
      exp_out   = q.pop_front();
      exp_valid = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ser_out_l"},   so_l, exp_out[0]);
    chk({tag, ".ser_valid_l"}, sv_l, exp_valid);
    chk({tag, ".busy_l"},      bz_l, exp_valid);
    chk({tag, ".done_l"},      dn_l, exp_done);
    chk({tag, ".ser_out_m"},   so_m, exp_out[1]);
    chk({tag, ".ser_valid_m"}, sv_m, exp_valid);
    chk({tag, ".busy_m"},      bz_m, exp_valid);
    chk({tag, ".done_m"},      dn_m, exp_done);
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic send(input string tag, input bit ud, input bit [7:0] din, input bit [3:0] r);
    use_din = ud;
    d_in    = din;
    rpt     = r;
    start   = 1'b1;
    cycle(tag);
    start   = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    use_din = 1'b0;
    d_in    = 8'h00;
    rpt     = 4'd0;
    @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    run("idle", 2);

    // Default pattern, single word, then DONE.
    send("pattern", 1'b0, 8'h00, 4'd0);
    run("pattern", 10);

    // D_IN word repeated three times back to back.
    send("din_rpt", 1'b1, 8'h3C, 4'd2);
    run("din_rpt", 30);

    // Start request mid-word is ignored.
    send("ignore", 1'b0, 8'h00, 4'd0);
    run("ignore", 3);
    use_din = 1'b1;
    d_in    = 8'hFF;
    rpt     = 4'd5;
    start   = 1'b1;
    cycle("ignore");
    start   = 1'b0;
    run("ignore", 8);

    // Abort while the fifth bit is on the line.
    send("abort", 1'b1, 8'hA7, 4'd1);
    run("abort", 4);
    abort = 1'b1;
    cycle("abort");
    abort = 1'b0;
    run("abort_idle", 2);
    send("after_abort", 1'b1, 8'h5B, 4'd0);
    run("after_abort", 11);

    // Abort and start together in IDLE: no start.
    abort = 1'b1;
    start = 1'b1;
    cycle("abort_start");
    abort = 1'b0;
    start = 1'b0;
    run("abort_start", 2);

    // Asynchronous reset mid-word.
    send("mid_rst", 1'b1, 8'hE1, 4'd3);
    run("mid_rst", 3);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_valid = 1'b0;
    exp_out   = 2'b00;
    exp_done  = 1'b0;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("in_rst");
    rst_n = 1'b1;
    send("post_rst", 1'b0, 8'h00, 4'd0);
    run("post_rst", 11);

    // START held through DONE: one idle cycle between transmissions.
    use_din = 1'b1;
    d_in    = 8'h96;
    rpt     = 4'd0;
    start   = 1'b1;
    run("b2b", 25);
    start   = 1'b0;
    run("b2b", 12);

    // Maximum repeat count: all 16 words must go out.
    send("rpt_max", 1'b1, 8'h4D, 4'd15);
    run("rpt_max", 16 * 9 + 4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 40) == 0);
      use_din = 1'($urandom_range(0, 1));
      d_in    = 8'($urandom);
      rpt     = 4'($urandom_range(0, 3));
      cycle("random");
    end
    start = 1'b0;
    abort = 1'b0;
    run("drain", 45);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
